cordic_arbiter: RTL and testbench

- Shares one combinational CORDIC unit between NREQ requesters.
- Registers the winning request's operands onto the unit and waits SETTLE cycles, so the unit's deep combinational chain is a timed multicycle path.
- Captures the result and returns it on a single response channel tagged with the requester index.
- Sits between the angle/vector producers and the CORDIC datapath; all values are Q4.28.

---
 rtl/cordic_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//   Round-robin arbiter sharing one combinational CORDIC unit among NREQ
//   requesters. The winner's operands are registered onto the unit and held
//   for SETTLE cycles. This lets the unit's long combinational chain be
//   constrained as a multicycle path. The selected result pair is then
//   captured and returned on one response channel, tagged with the
//   requester index. No arithmetic is done here; values are Q4.28 when N=32.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    per-requester handshake; at most one ready bit high
//   req_trig_rot       per-requester mode: 1 = sin/cos of angle, 0 = rotate
//   req_angle/xi/yi    flattened operands, requester k at [k*N +: N]
//   cu_*  (out)        registered operands driving the CORDIC unit
//   cu_sin/cos/xr/yr   CORDIC unit results
//   rsp_valid/ready    response handshake
//   rsp_id, rsp_mode   served requester and its mode
//   rsp_a, rsp_b       cos/sin (mode 1) or Xr/Yr (mode 0)
//   busy               high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module cordic_arbiter #(
   parameter int N      = 32,
   parameter int NREQ   = 2,
   parameter int IDW    = 1,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_trig_rot,
   input  logic [NREQ*N-1:0]    req_angle,
   input  logic [NREQ*N-1:0]    req_xi,
   input  logic [NREQ*N-1:0]    req_yi,
   output logic                 cu_trig_rot,
   output logic [N-1:0]         cu_angle,
   output logic [N-1:0]         cu_xi,
   output logic [N-1:0]         cu_yi,
   input  logic [N-1:0]         cu_sin,
   input  logic [N-1:0]         cu_cos,
   input  logic [N-1:0]         cu_xr,
   input  logic [N-1:0]         cu_yr,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_mode,
   output logic [N-1:0]         rsp_a,
   output logic [N-1:0]         rsp_b,
   output logic                 busy
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef struct packed {
      logic         trig_rot;
      logic [N-1:0] angle;
      logic [N-1:0] xi;
      logic [N-1:0] yi;
   } op_t;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

   state_t                    state, state_nxt;
   logic   [IDW-1:0]          ptr;
   logic   [IDW-1:0]          ptr_nxt;
   logic   [CW-1:0]           cnt;
   logic   [IDW-1:0]          srv_id;

   op_t    [NREQ-1:0]         lane_op;
   logic   [NREQ-1:0][IDW-1:0] lane_rank;

   logic                      gnt_any;
   logic   [IDW-1:0]          gnt_idx;
   logic   [IDW-1:0]          best_rank;
   op_t                       gnt_op;
   logic                      accept;

   // Per-requester slice: unpack operands and compute the distance from the
   // round-robin pointer. Rank 0 is the requester at ptr, rank NREQ-1 the
   // one just before it, so the lowest valid rank is the next in rotation.
   for (genvar k = 0; k < NREQ; k++) begin : g_lane
      assign lane_op[k] = {req_trig_rot[k], req_angle[k*N +: N],
                           req_xi[k*N +: N], req_yi[k*N +: N]};
      assign lane_rank[k] = (int'(ptr) > k) ? IDW'(NREQ + k - int'(ptr))
                                            : IDW'(k - int'(ptr));
   end

   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      best_rank = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[k] && (!gnt_any || lane_rank[k] < best_rank)) begin
            gnt_any   = 1'b1;
            gnt_idx   = IDW'(k);
            best_rank = lane_rank[k];
         end
      end
   end

   assign gnt_op  = lane_op[gnt_idx];
   assign ptr_nxt = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

   // Ready is gated by rst_n so nothing can look accepted while reset is low.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == S_IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   assign accept = |(req_valid & req_ready);
   assign busy   = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept)      state_nxt = S_SETTLE;
         S_SETTLE: if (cnt == '0)   state_nxt = S_RESP;
         S_RESP:   if (rsp_ready)   state_nxt = S_IDLE;
         default:                   state_nxt = S_IDLE;
      endcase
   end

   // Operand launch, settle countdown and result capture. cu_* only change
   // on an accept, so the unit never sees un-accepted data and holds its
   // inputs through the whole settle window. rsp_id/rsp_mode are copied at
   // capture time so the response fields only move together with rsp_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         cnt         <= '0;
         srv_id      <= '0;
         cu_trig_rot <= 1'b0;
         cu_angle    <= '0;
         cu_xi       <= '0;
         cu_yi       <= '0;
         rsp_valid   <= 1'b0;
         rsp_id      <= '0;
         rsp_mode    <= 1'b0;
         rsp_a       <= '0;
         rsp_b       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cu_trig_rot <= gnt_op.trig_rot;
                  cu_angle    <= gnt_op.angle;
                  cu_xi       <= gnt_op.xi;
                  cu_yi       <= gnt_op.yi;
                  srv_id      <= gnt_idx;
                  ptr         <= ptr_nxt;
                  cnt         <= CW'(SETTLE - 1);
               end
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  // Mux select is the registered mode, so the unused result
                  // pair (possibly undriven) never reaches the response.
                  rsp_valid <= 1'b1;
                  rsp_id    <= srv_id;
                  rsp_mode  <= cu_trig_rot;
                  rsp_a     <= cu_trig_rot ? cu_cos : cu_xr;
                  rsp_b     <= cu_trig_rot ? cu_sin : cu_yr;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_arbiter
//   Two arbiters (SETTLE=2 and SETTLE=1) share one stimulus stream. Each has
//   a stub CORDIC unit whose unselected result pair is poisoned, a timeline
//   model of the round-robin grant / settle / response behaviour, and a
//   scoreboard queue checked by an independent response monitor.
// -----------------------------------------------------------------------------
module tb_cordic_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 2;
   localparam int IDW  = 1;

   localparam logic [N-1:0] PI4    = 32'h0C90_FDAA;
   localparam logic [N-1:0] PI2    = 32'h1921_FB54;
   localparam logic [N-1:0] COS45  = 32'h0B50_4F33;
   localparam logic [N-1:0] POISON = 32'hDEAD_BEEF;

   logic                 clk   = 1'b0;
   logic                 rst_n = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_trig_rot = '0;
   logic [NREQ*N-1:0]    req_angle = '0;
   logic [NREQ*N-1:0]    req_xi = '0;
   logic [NREQ*N-1:0]    req_yi = '0;
   logic                 rsp_ready = 1'b1;
   int                   cyc = 0;
   bit                   done = 1'b0;
   int                   n_chk = 0;
   int                   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub unit behaviour; pi/4 maps to the true Q4.28 cos/sin value.
   function automatic logic [N-1:0] f_cos(input logic [N-1:0] a);
      return (a == PI4) ? COS45 : (a ^ 32'h5A5A_5A5A);
   endfunction
   function automatic logic [N-1:0] f_sin(input logic [N-1:0] a);
      return (a == PI4) ? COS45 : (a + 32'h1357_9BDF);
   endfunction
   function automatic logic [N-1:0] f_xr(input logic [N-1:0] x, input logic [N-1:0] a);
      return x ^ {a[15:0], a[31:16]};
   endfunction
   function automatic logic [N-1:0] f_yr(input logic [N-1:0] y, input logic [N-1:0] a);
      return y - a;
   endfunction

   typedef struct {
      logic [IDW-1:0] id;
      logic           mode;
      logic [N-1:0]   a;
      logic [N-1:0]   b;
      int             acc;   // posedge number of the accept edge
   } exp_t;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int S = (gi == 0) ? 2 : 1;

      logic [NREQ-1:0] req_ready;
      logic            cu_trig_rot;
      logic [N-1:0]    cu_angle, cu_xi, cu_yi;
      logic [N-1:0]    cu_sin, cu_cos, cu_xr, cu_yr;
      logic            rsp_valid, rsp_mode, busy;
      logic [IDW-1:0]  rsp_id;
      logic [N-1:0]    rsp_a, rsp_b;

      cordic_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .SETTLE(S)) dut (
         .clk(clk), .rst_n(rst_n),
         .req_valid(req_valid), .req_ready(req_ready),
         .req_trig_rot(req_trig_rot), .req_angle(req_angle),
         .req_xi(req_xi), .req_yi(req_yi),
         .cu_trig_rot(cu_trig_rot), .cu_angle(cu_angle),
         .cu_xi(cu_xi), .cu_yi(cu_yi),
         .cu_sin(cu_sin), .cu_cos(cu_cos), .cu_xr(cu_xr), .cu_yr(cu_yr),
         .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
         .rsp_mode(rsp_mode), .rsp_a(rsp_a), .rsp_b(rsp_b), .busy(busy)
      );

      // The pair not matching the current mode is poisoned to expose leaks.
      assign cu_cos = cu_trig_rot ? f_cos(cu_angle) : POISON;
      assign cu_sin = cu_trig_rot ? f_sin(cu_angle) : POISON;
      assign cu_xr  = cu_trig_rot ? ~POISON : f_xr(cu_xi, cu_angle);
      assign cu_yr  = cu_trig_rot ? ~POISON : f_yr(cu_yi, cu_angle);

      exp_t            q[$];
      bit              m_busy = 1'b0;
      int              m_ptr = 0, m_cyc = 0, g, k;
      logic            m_trig;
      logic [N-1:0]    m_ang, m_xi, m_yi;
      logic [NREQ-1:0] exp_rdy;
      exp_t            ne;

      // Model: idle -> accept -> S settle edges -> response held until
      // rsp_ready -> idle. Runs at negedge, then advances to the next edge.
      always @(negedge clk) begin
         if (!rst_n) begin
            n_chk++;
            if ({req_ready, busy, rsp_valid, rsp_id, rsp_mode, rsp_a, rsp_b,
                 cu_trig_rot, cu_angle, cu_xi, cu_yi} !== '0) begin
               n_err++;
               $display("FAIL reset_outputs S=%0d: got rdy=%b busy=%b vld=%b id=%h a=%h b=%h cu=%h/%h/%h want all 0",
                        S, req_ready, busy, rsp_valid, rsp_id, rsp_a, rsp_b, cu_angle, cu_xi, cu_yi);
            end
            m_busy = 1'b0;
            m_ptr  = 0;
            q.delete();
         end else begin
            g = -1;
            if (!m_busy)
               for (int r = 0; r < NREQ; r++) begin
                  k = (m_ptr + r) % NREQ;
                  if (g < 0 && req_valid[k]) g = k;
               end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;

            n_chk++;
            if (req_ready !== exp_rdy) begin
               n_err++;
               $display("FAIL grant S=%0d cyc=%0d: got req_ready=%b want %b", S, cyc, req_ready, exp_rdy);
            end
            n_chk++;
            if (!$onehot0(req_ready)) begin
               n_err++;
               $display("FAIL ready_onehot S=%0d: got %b want at most one bit", S, req_ready);
            end
            n_chk++;
            if (busy !== m_busy) begin
               n_err++;
               $display("FAIL busy S=%0d cyc=%0d: got %b want %b", S, cyc, busy, m_busy);
            end
            n_chk++;
            if (rsp_valid !== (m_busy && m_cyc >= S)) begin
               n_err++;
               $display("FAIL rsp_valid S=%0d cyc=%0d: got %b want %b", S, cyc, rsp_valid, m_busy && m_cyc >= S);
            end
            if (m_busy) begin
               n_chk++;
               if ({cu_trig_rot, cu_angle, cu_xi, cu_yi} !== {m_trig, m_ang, m_xi, m_yi}) begin
                  n_err++;
                  $display("FAIL cu_hold S=%0d: got %b/%h/%h/%h want %b/%h/%h/%h", S,
                           cu_trig_rot, cu_angle, cu_xi, cu_yi, m_trig, m_ang, m_xi, m_yi);
               end
            end

            if (m_busy) begin
               if (m_cyc >= S && rsp_ready) m_busy = 1'b0;
               else                         m_cyc++;
            end else if (g >= 0) begin
               m_trig = req_trig_rot[g];
               m_ang  = req_angle[g*N +: N];
               m_xi   = req_xi[g*N +: N];
               m_yi   = req_yi[g*N +: N];
               ne.id   = IDW'(g);
               ne.mode = m_trig;
               ne.a    = m_trig ? f_cos(m_ang) : f_xr(m_xi, m_ang);
               ne.b    = m_trig ? f_sin(m_ang) : f_yr(m_yi, m_ang);
               ne.acc  = cyc + 1;
               q.push_back(ne);
               m_busy = 1'b1;
               m_cyc  = 0;
               m_ptr  = (g + 1) % NREQ;
            end
         end
      end

      // Response monitor: compares whatever the DUT presents with the queue.
      bit   hold = 1'b0, fin = 1'b0;
      exp_t e;
      always @(negedge clk) begin
         if (rst_n && rsp_valid) begin
            n_chk++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL stale_rsp S=%0d: got id=%h a=%h b=%h want no response", S, rsp_id, rsp_a, rsp_b);
            end else begin
               e = q[0];
               if ({rsp_id, rsp_mode, rsp_a, rsp_b} !== {e.id, e.mode, e.a, e.b}) begin
                  n_err++;
                  $display("FAIL rsp_data S=%0d: got id=%h m=%b a=%h b=%h want id=%h m=%b a=%h b=%h",
                           S, rsp_id, rsp_mode, rsp_a, rsp_b, e.id, e.mode, e.a, e.b);
               end
               if (!hold) begin
                  n_chk++;
                  if (cyc + 1 - e.acc != S + 1) begin
                     n_err++;
                     $display("FAIL latency S=%0d: got %0d edges want %0d", S, cyc + 1 - e.acc, S + 1);
                  end
               end
               hold = 1'b1;
               if (rsp_ready) begin
                  void'(q.pop_front());
                  hold = 1'b0;
               end
            end
         end
         if (done && !fin) begin
            fin = 1'b1;
            n_chk++;
            if (q.size() != 0) begin
               n_err++;
               $display("FAIL drain S=%0d: got %0d outstanding want 0", S, q.size());
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_req(input int r, input logic m, input logic [N-1:0] a,
                          input logic [N-1:0] x, input logic [N-1:0] y);
      req_trig_rot[r]   = m;
      req_angle[r*N +: N] = a;
      req_xi[r*N +: N]    = x;
      req_yi[r*N +: N]    = y;
   endtask

   task automatic rand_ops();
      for (int r = 0; r < NREQ; r++)
         set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // Single sin/cos at pi/4 from requester 0
      set_req(0, 1'b1, PI4, 32'h0, 32'h0);
      req_valid = 2'b01;
      tick(1);
      req_valid = '0;
      tick(8);

      // Rotation of (1.0, 0) by pi/2 from requester 1
      set_req(1, 1'b0, PI2, 32'h1000_0000, 32'h0);
      req_valid = 2'b10;
      tick(1);
      req_valid = '0;
      tick(8);

      // Contention: both requesters continuously valid
      req_valid = 2'b11;
      for (int i = 0; i < 30; i++) begin
         rand_ops();
         tick(1);
      end
      req_valid = '0;
      tick(8);

      // Backpressure with the other requester still waiting
      rsp_ready = 1'b0;
      req_valid = 2'b11;
      tick(12);
      rsp_ready = 1'b1;
      tick(1);
      req_valid = '0;
      tick(8);

      // Reset one cycle after an accept, then a fresh request from req1
      req_valid = 2'b01;
      tick(1);
      req_valid = '0;
      tick(1);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      rand_ops();
      req_valid = 2'b10;
      tick(1);
      req_valid = '0;
      tick(8);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rand_ops();
         req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick(1);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      tick(10);
      done = 1'b1;
      tick(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
